// File: rtl/example_out_capture.sv
// example_out_capture
//   Captures the six single-bit outputs of the Example module, packs them into
//   a word {i,h,g,e,d,c}, and queues a word only when it differs from the last
//   queued one. The first word after (re)enable is always queued. Queued
//   words leave on a valid/ready stream. Words arriving while the FIFO is full
//   are dropped and counted.
//
//   Optional feature macro: CAPTURE_TIMESTAMP_EN
//     Adds parameter TS_W and output out_ts. Each entry then carries the value
//     of a free-running cycle counter taken at its push edge.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   en                    sampling enable
//   c, d, e, g, h, i      Example outputs
//   out_valid/out_ready   stream handshake, out_data = head word
//   full                  FIFO holds DEPTH entries
//   overflow              sticky, at least one word dropped
//   drop_cnt              saturating count of dropped words
//   out_ts                head timestamp, 0 when empty (CAPTURE_TIMESTAMP_EN only)
module example_out_capture #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
`ifdef CAPTURE_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             g,
    input  logic             h,
    input  logic             i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_data,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
`ifdef CAPTURE_TIMESTAMP_EN
    , output logic [TS_W-1:0] out_ts
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    logic [1:0]  state;
    logic [5:0]  samp;
    logic [5:0]  last_pushed;
    logic [5:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    logic [5:0]  in_word;
    logic        empty;
    logic        push_req;
    logic        do_pop;
    logic        do_push;
    logic        do_drop;

    assign in_word = {i, h, g, e, d, c};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // PRIME pushes whatever was sampled; TRACK pushes only on change.
    assign push_req = en && ((state == ST_PRIME) ||
                             ((state == ST_TRACK) && (samp != last_pushed)));
    assign do_pop   = out_valid && out_ready;
    // A same-edge pop frees a slot, so a full FIFO still accepts the push.
    assign do_push  = push_req && (!full || do_pop);
    assign do_drop  = push_req && full && !do_pop;

    assign out_valid = !empty;
    assign out_data  = empty ? 6'd0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            samp        <= 6'd0;
            last_pushed <= 6'd0;
        end else begin
            if (en) begin
                samp <= in_word;
                case (state)
                    ST_IDLE:  state <= ST_PRIME;
                    ST_PRIME: state <= ST_TRACK;
                    ST_TRACK: state <= ST_TRACK;
                    default:  state <= ST_IDLE;
                endcase
            end else begin
                state <= ST_IDLE;
            end
            // Updated even when the word is dropped, so an unchanged value
            // is not re-requested every cycle.
            if (push_req)
                last_pushed <= samp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
            if (do_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}})
                    drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= samp;
    end

`ifdef CAPTURE_TIMESTAMP_EN
    localparam logic [TS_W-1:0] TS_ONE = 1;

    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + TS_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            ts_mem[wptr[AW-1:0]] <= ts_cnt;
    end

    assign out_ts = empty ? '0 : ts_mem[rptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_example_out_capture.sv
module tb_example_out_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       c, d, e, g, h, i;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic       full;
    logic       overflow;
    logic [7:0] drop_cnt;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [3:0] out_ts;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

`ifdef CAPTURE_TIMESTAMP_EN
    example_out_capture #(.DEPTH(4), .CNT_W(8), .TS_W(4)) dut (
`else
    example_out_capture #(.DEPTH(4), .CNT_W(8)) dut (
`endif
        .clk(clk), .rst_n(rst_n), .en(en),
        .c(c), .d(d), .e(e), .g(g), .h(h), .i(i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef CAPTURE_TIMESTAMP_EN
        , .out_ts(out_ts)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [5:0] w);
        {i, h, g, e, d, c} = w;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        // thin printer only; each test computes its own expectation inline
        cmp_cnt++;
        if (act !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; set_word(6'h00);
        tick(); tick();
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        cmp_cnt++; if (out_data !== 6'h00) begin err_cnt++; $display("FAIL reset_data: got %h expected 00", out_data); end
        cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b expected 0", full); end
        cmp_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        cmp_cnt++; if (drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_prime();
        set_word(6'h00); en = 1'b1; out_ready = 1'b0;
        tick();  // sample
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL prime_early: got %b expected 0", out_valid); end
        tick();  // prime push
        cmp_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL prime_valid: got %b expected 1", out_valid); end
        cmp_cnt++; if (out_data !== 6'h00) begin err_cnt++; $display("FAIL prime_data: got %h expected 00", out_data); end
        tick(); tick(); tick();
        out_ready = 1'b1;
        tick();  // pop the single entry; static inputs must not have added more
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL prime_single: got %b expected 0", out_valid); end
    endtask

    task automatic test_track();
        logic [5:0] words [2];
        words[0] = 6'h08; words[1] = 6'h09;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_word(words[k]);
            tick();
            cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL track_early%0d: got %b expected 0", k, out_valid); end
            tick();
            cmp_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL track_valid%0d: got %b expected 1", k, out_valid); end
            cmp_cnt++; if (out_data !== words[k]) begin err_cnt++; $display("FAIL track_data%0d: got %h expected %h", k, out_data, words[k]); end
            tick();
            cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL track_once%0d: got %b expected 0", k, out_valid); end
        end
        tick(); tick();
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL track_static: got %b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        en = 1'b0; tick();            // back to IDLE
        en = 1'b1; set_word(6'h10);
        tick();                        // sample 10
        for (int k = 1; k <= 6; k++) begin
            set_word(6'(6'h10 + k));
            tick();                    // pushes the previous sample
            if (k == 4) begin
                cmp_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL ovf_full4: got %b expected 1", full); end
                cmp_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        tick();                        // pushes 16 -> third drop
        tick();                        // static, nothing more
        cmp_cnt++; if (drop_cnt !== 8'd3) begin err_cnt++; $display("FAIL ovf_drop_cnt: got %0d expected 3", drop_cnt); end
        cmp_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        cmp_cnt++; if (out_data !== 6'h10) begin err_cnt++; $display("FAIL ovf_hold: got %h expected 10", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmp_cnt++;
            if (out_data !== 6'(6'h10 + k)) begin err_cnt++; $display("FAIL ovf_order%0d: got %h expected %h", k, out_data, 6'(6'h10 + k)); end
            tick();
        end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
        cmp_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_kept: got %b expected 1", overflow); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_word(6'(6'h20 + k));
            tick();
        end
        set_word(6'h24);
        tick();                        // pushes 23 -> [20,21,22,23]
        cmp_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL b2b_full: got %b expected 1", full); end
        cmp_cnt++; if (out_data !== 6'h20) begin err_cnt++; $display("FAIL b2b_head: got %h expected 20", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_word(6'(6'h25 + k));
            tick();                    // pop head, push previous sample
            cmp_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL b2b_full%0d: got %b expected 1", k, full); end
            cmp_cnt++; if (out_data !== 6'(6'h21 + k)) begin err_cnt++; $display("FAIL b2b_data%0d: got %h expected %h", k, out_data, 6'(6'h21 + k)); end
        end
        // queue [26,27,28,29], 2A still sampled and pending
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                cmp_cnt++; if (out_data !== 6'(6'h27 + k)) begin err_cnt++; $display("FAIL b2b_drain%0d: got %h expected %h", k, out_data, 6'(6'h27 + k)); end
            end else begin
                cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
            end
        end
        cmp_cnt++; if (drop_cnt !== 8'd3) begin err_cnt++; $display("FAIL b2b_no_drop: got %0d expected 3", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] seq [4];
        seq[0] = 6'h01; seq[1] = 6'h02; seq[2] = 6'h03; seq[3] = 6'h2A;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_word(seq[k]);
            tick();
        end
        cmp_cnt++; if (out_data !== 6'h01) begin err_cnt++; $display("FAIL mid_head: got %h expected 01", out_data); end
        cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL mid_notfull: got %b expected 0", full); end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL mid_full: got %b expected 0", full); end
        cmp_cnt++; if (drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL mid_drop_cnt: got %0d expected 0", drop_cnt); end
        cmp_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
        rst_n = 1'b1;
        tick();                        // sample 2A
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_reprime_early: got %b expected 0", out_valid); end
        tick();                        // prime push
        cmp_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_reprime_valid: got %b expected 1", out_valid); end
        cmp_cnt++; if (out_data !== 6'h2A) begin err_cnt++; $display("FAIL mid_reprime_data: got %h expected 2a", out_data); end
    endtask

`ifdef CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        en = 1'b0; out_ready = 1'b0; set_word(6'h00);
        rst_n = 1'b0; #1 rst_n = 1'b1;
        tick(); tick();                // counter 0,1 consumed
        en = 1'b1;
        tick();                        // edge at ts=2: sample
        tick();                        // edge at ts=3: push
        cmp_cnt++; if (out_ts !== 4'd3) begin err_cnt++; $display("FAIL ts_first: got %0d expected 3", out_ts); end
        out_ready = 1'b1;
        tick();                        // ts=4: pop
        cmp_cnt++; if (out_ts !== 4'd0) begin err_cnt++; $display("FAIL ts_empty: got %0d expected 0", out_ts); end
        for (int k = 5; k < 18; k++) tick();
        set_word(6'h01);
        tick();                        // ts=18: sample
        tick();                        // ts=19: push
        cmp_cnt++; if (out_ts !== 4'd3) begin err_cnt++; $display("FAIL ts_wrap: got %0d expected 3", out_ts); end
    endtask
`endif

    initial begin
        test_reset();
        test_prime();
        test_track();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
